// File: rtl/arb_pkg.sv
// Shared types for the I/D SRAM port arbiter: response owner, FSM state
// and the default byte-strobe width.
package arb_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OUT  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int STRB_W     = DEF_DATA_W / 8;

endpackage

// File: rtl/arb_prio_starve.sv
// Fixed D-over-I priority with a saturating starvation counter that hands
// I the port once it has lost STARVE_LIMIT consecutive cycles.
module arb_prio_starve #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  output logic gnt_i,
  output logic gnt_d
);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       d_first;

  always_comb begin
    d_first      = (32'(starve_cnt_q) < STARVE_LIMIT);
    // Nothing is accepted while reset is held so no response outlives it.
    gnt_d        = !reset && d_req && (d_first || !i_req);
    gnt_i        = !reset && i_req && !(d_req && d_first);
    starve_cnt_d = 4'd0;
    if (i_req && gnt_d)
      starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= 4'd0;
    else       starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between fetch (I) and load/store (D).
// Optional ARB_PERF_CNT_EN adds grant/conflict performance counters.
module sram_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_i_grants,
  output logic [31:0]         perf_d_grants,
  output logic [31:0]         perf_conflicts
`endif
);

  logic              gnt_i, gnt_d, rsp_live;
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;

  arb_prio_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk   (clk),
    .reset (reset),
    .i_req (i_req),
    .d_req (d_req),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  assign i_addr_ok  = gnt_i;
  assign d_addr_ok  = gnt_d;
  assign sram_en    = gnt_i | gnt_d;
  assign sram_we    = (gnt_d && d_wr) ? d_wstrb : '0;
  assign sram_addr  = gnt_d ? d_addr : (gnt_i ? i_addr : addr_q);
  assign sram_wdata = gnt_d ? d_wdata : wdata_q;

  // Reset in the response cycle swallows the outstanding data_ok.
  assign rsp_live   = (state_q == ST_OUT) && !reset;
  assign i_data_ok  = rsp_live && (owner_q == OWN_I);
  assign d_data_ok  = rsp_live && (owner_q == OWN_D);
  assign i_rdata    = i_data_ok ? sram_rdata : i_rdata_q;
  assign d_rdata    = d_data_ok ? sram_rdata : d_rdata_q;

  always_comb begin
    state_d = sram_en ? ST_OUT : ST_IDLE;
    owner_d = owner_q;
    if (gnt_d)      owner_d = OWN_D;
    else if (gnt_i) owner_d = OWN_I;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= sram_addr;
      wdata_q <= sram_wdata;
      if (i_data_ok) i_rdata_q <= sram_rdata;
      if (d_data_ok) d_rdata_q <= sram_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_q, perf_d_q, perf_c_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_c_q <= '0;
    end else begin
      if (gnt_i)         perf_i_q <= perf_i_q + 32'd1;
      if (gnt_d)         perf_d_q <= perf_d_q + 32'd1;
      if (i_req && d_req) perf_c_q <= perf_c_q + 32'd1;
    end
  end

  assign perf_i_grants  = perf_i_q;
  assign perf_d_grants  = perf_d_q;
  assign perf_conflicts = perf_c_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized + directed bench for sram_port_arbiter against a behavioural
// model of grants, responses and memory contents.
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk, reset;
  logic        i_req, i_addr_ok, i_data_ok;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_addr_ok, d_data_ok;
  logic [3:0]  d_wstrb, sram_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        sram_en;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i, perf_d, perf_c;
`endif

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_grants(perf_i), .perf_d_grants(perf_d), .perf_conflicts(perf_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // SRAM behaviour: request sampled mid-cycle, read-before-write at posedge.
  logic [31:0] sram_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  logic        s_en;
  logic [3:0]  s_we;
  logic [31:0] s_addr, s_wdata;

  always @(negedge clk) begin
    s_en = sram_en; s_we = sram_we; s_addr = sram_addr; s_wdata = sram_wdata;
  end

  always @(posedge clk) begin
    if (s_en) begin
      logic [31:0] w;
      w = sram_mem.exists(s_addr) ? sram_mem[s_addr] : 32'd0;
      sram_rdata <= w;
      for (int b = 0; b < 4; b++) if (s_we[b]) w[b*8 +: 8] = s_wdata[b*8 +: 8];
      sram_mem[s_addr] = w;
    end
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    sram_mem[a] = v;
    ref_mem[a]  = v;
  endtask

  // Reference model: who wins, what comes back next cycle, what each rdata holds.
  int          m_lost;
  bit          pend_i, pend_d, m_acc_i, m_acc_d, addr_seen;
  logic [31:0] pend_i_dat, pend_d_dat, hold_i, hold_d, last_addr;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_i_addr_ok", i_addr_ok, 0);
      check("rst_d_addr_ok", d_addr_ok, 0);
      check("rst_i_data_ok", i_data_ok, 0);
      check("rst_d_data_ok", d_data_ok, 0);
      check("rst_sram_en", sram_en, 0);
      check("rst_sram_we", sram_we, 0);
      m_lost = 0; pend_i = 0; pend_d = 0; m_acc_i = 0; m_acc_d = 0;
      hold_i = 0; hold_d = 0; addr_seen = 0;
    end else begin
      bit gi, gd;
      logic [31:0] ei, ed, w;
      gd = d_req && (m_lost < LIMIT || !i_req);
      gi = i_req && !gd;
      check("i_addr_ok", i_addr_ok, gi);
      check("d_addr_ok", d_addr_ok, gd);
      check("sram_en", sram_en, gi | gd);
      check("sram_we", sram_we, (gd && d_wr) ? d_wstrb : 4'd0);
      if (gi || gd) check("sram_addr", sram_addr, gd ? d_addr : i_addr);
      else if (addr_seen) check("sram_addr_hold", sram_addr, last_addr);
      if (gd && d_wr) check("sram_wdata", sram_wdata, d_wdata);
      check("i_data_ok", i_data_ok, pend_i);
      check("d_data_ok", d_data_ok, pend_d);
      ei = pend_i ? pend_i_dat : hold_i;
      ed = pend_d ? pend_d_dat : hold_d;
      check("i_rdata", i_rdata, ei);
      check("d_rdata", d_rdata, ed);
      hold_i = ei; hold_d = ed;
      pend_i = gi; pend_d = gd;
      if (gi) begin pend_i_dat = ref_rd(i_addr); last_addr = i_addr; addr_seen = 1; end
      if (gd) begin
        pend_d_dat = ref_rd(d_addr); last_addr = d_addr; addr_seen = 1;
        if (d_wr) begin
          w = pend_d_dat;
          for (int b = 0; b < 4; b++) if (d_wstrb[b]) w[b*8 +: 8] = d_wdata[b*8 +: 8];
          ref_mem[d_addr] = w;
        end
      end
      m_lost = (i_req && gd) ? ((m_lost < 15) ? m_lost + 1 : 15) : 0;
      m_acc_i = gi; m_acc_d = gd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_wstrb = 0;
    d_addr = 0; d_wdata = 0;
    repeat (3) step();
    reset = 0;
    @(negedge clk);
    check("post_rst_i_rdata", i_rdata, 32'd0);
    check("post_rst_d_rdata", d_rdata, 32'd0);
    check("post_rst_sram_en", sram_en, 0);

    // Single fetch
    preload(32'h1c000000, 32'hDEADBEEF);
    step(); i_req = 1; i_addr = 32'h1c000000;
    @(negedge clk); check("t1_addr_ok", i_addr_ok, 1);
    step(); i_req = 0;
    @(negedge clk);
    check("t1_data_ok", i_data_ok, 1);
    check("t1_rdata", i_rdata, 32'hDEADBEEF);
    check("t1_d_data_ok", d_data_ok, 0);
    check("t1_d_rdata", d_rdata, 32'd0);

    // Partial store then load
    preload(32'h100, 32'hFFFFFFFF);
    step(); d_req = 1; d_wr = 1; d_addr = 32'h100; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    @(negedge clk);
    check("t2_we", sram_we, 4'b0011);
    check("t2_st_addr_ok", d_addr_ok, 1);
    step(); d_wr = 0; d_wstrb = 0;
    @(negedge clk);
    check("t2_st_data_ok", d_data_ok, 1);
    check("t2_ld_addr_ok", d_addr_ok, 1);
    step(); d_req = 0;
    @(negedge clk);
    check("t2_ld_data_ok", d_data_ok, 1);
    check("t2_ld_rdata", d_rdata, 32'hFFFF5678);

    // Contention: D,D,D,D,I repeating
    step(); i_req = 1; i_addr = 32'h40; d_req = 1; d_wr = 0; d_addr = 32'h44;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_d_win", d_addr_ok, (k % 5) != 4);
      check("t3_i_win", i_addr_ok, (k % 5) == 4);
      step();
    end
    i_req = 0; d_req = 0;

    // Back-to-back fetches
    preload(32'h0, 32'hA0A0A0A0); preload(32'h4, 32'hA4A4A4A4); preload(32'h8, 32'hA8A8A8A8);
    step(); i_req = 1; i_addr = 32'h0;
    @(negedge clk); check("t4_ok0", i_addr_ok, 1);
    step(); i_addr = 32'h4;
    @(negedge clk); check("t4_ok1", i_addr_ok, 1); check("t4_rd0", i_rdata, 32'hA0A0A0A0);
    step(); i_addr = 32'h8;
    @(negedge clk); check("t4_ok2", i_addr_ok, 1); check("t4_rd1", i_rdata, 32'hA4A4A4A4);
    step(); i_req = 0;
    @(negedge clk); check("t4_dok2", i_data_ok, 1); check("t4_rd2", i_rdata, 32'hA8A8A8A8);
    step();
    @(negedge clk); check("t4_idle", i_data_ok, 0);

    // Reset while a load is outstanding
    d_req = 1; d_wr = 0; d_addr = 32'h100;
    @(negedge clk); check("t5_addr_ok", d_addr_ok, 1);
    step(); d_req = 0; reset = 1;
    @(negedge clk); check("t5_no_dok", d_data_ok, 0);
    step(); reset = 0;
    @(negedge clk);
    check("t5_dok", d_data_ok, 0);
    check("t5_d_rdata", d_rdata, 32'd0);
    check("t5_i_rdata", i_rdata, 32'd0);
    check("t5_en", sram_en, 0);

`ifdef ARB_PERF_CNT_EN
    step(); i_req = 1; d_req = 1; i_addr = 32'h8; d_addr = 32'hC;
    repeat (10) step();
    i_req = 0; d_req = 0;
    @(negedge clk);
    check("perf_conflicts", perf_c, 32'd10);
    check("perf_sum", perf_i + perf_d, 32'd10);
`endif

    // Random traffic obeying the hold-until-accepted rule
    for (int c = 0; c < 800; c++) begin
      step();
      if (!i_req || m_acc_i) begin
        i_req = ($urandom_range(0, 3) != 0);
        i_addr = rnd_addr();
      end
      if (!d_req || m_acc_d) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_wr = 1'($urandom_range(0, 1));
        d_wstrb = 4'($urandom_range(0, 15));
        d_addr = rnd_addr();
        d_wdata = $urandom;
      end
    end
    step(); i_req = 0; d_req = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the CPU instruction-fetch requester (I) and the load/store requester (D).
- Each requester uses a req/addr_ok/data_ok handshake; the SRAM side uses en/we/addr/wdata/rdata with 1-cycle read latency.
- Fixed priority D > I, plus an anti-starvation counter that forces an I grant after a bounded number of lost cycles.
- Sits between the CPU core and the unified memory, replacing the separate inst/data SRAM ports.

Parameters:
- ADDR_W, 32, address width of requesters and SRAM.
- DATA_W, 32, data width; byte strobes are DATA_W/8.
- STARVE_LIMIT, 4, consecutive cycles I may lose arbitration before it is forced to win; range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_addr_ok  out  1  fetch request accepted this cycle
- i_data_ok  out  1  fetch data valid this cycle
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  load/store request
- d_wr  in  1  1 = store
- d_wstrb  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_addr_ok  out  1  load/store request accepted
- d_data_ok  out  1  load data valid / store complete
- d_rdata  out  DATA_W  load data
- sram_en  out  1  SRAM access enable
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after en

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- State: two-state FSM, IDLE and OUT (one access outstanding); owner register (I/D); starvation counter starve_cnt, 4 bits.
- Grant (combinational, any state):
  - If d_req and starve_cnt < STARVE_LIMIT, grant D.
  - Else if i_req, grant I.
  - Else if d_req, grant D.
- Acceptance:
  - A granted requester gets addr_ok=1 in the same cycle.
  - sram_en=1 in that cycle. sram_addr and sram_wdata come from the winner.
  - sram_we = d_wstrb when D wins with d_wr=1, else 0.
  - Outputs are combinational from inputs: zero added request latency.
- Response:
  - The cycle after acceptance, the FSM is in OUT and the owner's data_ok=1 for exactly one cycle.
  - The owner's rdata = sram_rdata. Stores also get data_ok.
  - The non-owner's data_ok=0 and its rdata holds its last value.
- Back-to-back: in OUT, a new request may be accepted in the same cycle as data_ok. The FSM stays in OUT with the new owner; otherwise it returns to IDLE. Sustained throughput is 1 access/cycle.
- Starvation counter:
  - Increments, saturating at 15, when i_req=1 and D wins.
  - Clears when I wins or i_req=0.
- Unused SRAM lines: when no grant, sram_en=0, sram_we=0, and addr/wdata hold their last value.
- Requester rule: a requester keeps req and payload stable until addr_ok; the arbiter does not latch unaccepted requests.
- Reset values: FSM=IDLE, owner=I, starve_cnt=0, all *_addr_ok/*_data_ok=0, i_rdata=d_rdata=0, sram_en=0, sram_we=0.
- Reset during OUT: the outstanding response is dropped and no data_ok is issued after reset.
- Simultaneous i_req and d_req with starve_cnt == STARVE_LIMIT: I wins and the counter clears.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_i_grants[31:0], perf_d_grants[31:0] and perf_conflicts[31:0].
  - perf_conflicts counts cycles with both reqs high.
  - All three counters wrap, are cleared by reset, and update on accepted grants.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package arb_pkg holds:
  - owner enum (OWN_I=0, OWN_D=1);
  - FSM state enum (ST_IDLE, ST_OUT);
  - localparam STRB_W = DATA_W/8.
- One sub-module, arb_prio_starve: grant logic plus the starvation counter. Inputs i_req, d_req; outputs gnt_i, gnt_d.

Test Plan:
- After reset, I reads 0x1c000000 with memory word 0xDEADBEEF → i_addr_ok in cycle 0, i_data_ok in cycle 1, i_rdata=0xDEADBEEF; all D outputs 0.
- D store to 0x100, wdata 0x12345678, wstrb 0b0011, then D load from 0x100, preloaded 0xFFFFFFFF → sram_we=0011 on the store; load returns 0xFFFF5678; d_data_ok pulses for both.
- Both reqs held high continuously, STARVE_LIMIT=4 → grant pattern D,D,D,D,I repeating; each data_ok goes to the correct owner one cycle after its accept.
- Back-to-back I reads to 0x0, 0x4, 0x8 → addr_ok on 3 consecutive cycles; data_ok on the next 3 cycles with matching data; FSM never returns to IDLE between them.
- Reset asserted in the cycle after a D load is accepted → no d_data_ok; all outputs at reset values on the next cycle.
- With ARB_PERF_CNT_EN, 10 cycles of both reqs high → perf_conflicts=10 and perf_i_grants + perf_d_grants = 10.
